aes_128_inv: RTL and testbench

- Iterative AES-128 inverse cipher, one round per clock. It is the decrypt counterpart of aes_128.
- Takes a 128-bit ciphertext and the original cipher key. It expands the key forward to the round-10 key, then decrypts while regenerating round keys in reverse.
- Used on the bench to round-trip aes_128 outputs. Used in the CED path as a decrypt-and-compare checker.
- Carries a sticky fault_detected flag for illegal control states.

---
 rtl/aes_pkg.sv | 113 +++++++++++
 rtl/aes_inv_sbox.sv | 11 +
 rtl/aes_sbox.sv | 11 +
 rtl/aes_128_inv.sv | 184 ++++++++++++++++++
 tb/tb_aes_128_inv.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: control states, round constants, GF(2^8) arithmetic,
// S-box mappings and the inverse-cipher state transforms.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } aes_state_e;

  localparam logic [3:0] RCNT_LAST = 4'd10;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    mul9 = xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    mul11 = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    mul13 = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    mul14 = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (b[i] ? aa : 8'h00);
      aa = xtime(aa);
    end
    gf_mul = p;
  endfunction

  // Multiplicative inverse as x^254 (x^127 via x -> x^2*x chain, then square); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) begin
      r = gf_mul(gf_mul(r, r), x);
    end
    gf_inv = gf_mul(r, r);
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    sbox_fwd = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    sbox_inv = gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // Byte n lives at [127-8n -: 8]; row r of column c is byte 4c+r, rotated right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r) & 3) + r) -: 8];
      end
    end
    inv_shift_rows = o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
      o[119 - 32*c -: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
      o[111 - 32*c -: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
      o[103 - 32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
    end
    inv_mix_columns = o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, combinational 256-entry mapping (inverse affine map then GF inverse).
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = sbox_inv(x);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational (inverse in GF(2^8) followed by the affine map).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = sbox_fwd(x);

endmodule

// File: rtl/aes_128_inv.sv
// Iterative AES-128 inverse cipher: forward key expansion to k10, then one
// decryption round per clock while round keys are regenerated backwards.
module aes_128_inv
  import aes_pkg::*;
#(
  parameter bit RESTART_ON_START = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] data,
  output logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic         fault_detected
);

  aes_state_e   state_r, state_n;
  logic [3:0]   rcnt_r, rcnt_n;
  logic [127:0] key_r, key_n;
  logic [127:0] blk_r, blk_n;
  logic [127:0] pt_r, pt_n;
  logic         busy_r, busy_n;
  logic         done_r, done_n;
  logic         fault_r, fault_n;

  logic         legal_s;
  logic         accept_s;
  logic [31:0]  prev_w3_s, sb_in_s, rot_s, sub_s, rc_word_s, w0_s;
  logic [3:0]   rc_idx_s;
  logic [127:0] next_key_s, prev_key_s;
  logic [127:0] isr_s, isb_s, ark_s, round_s;

  // Round counter must match the range belonging to the current state
  always_comb begin
    legal_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_FINAL, ST_DONE: legal_s = (rcnt_r == 4'd0);
      ST_KEYEXP: legal_s = (rcnt_r >= 4'd1) && (rcnt_r <= RCNT_LAST);
      ST_INIT:   legal_s = (rcnt_r == RCNT_LAST);
      ST_ROUND:  legal_s = (rcnt_r >= 4'd1) && (rcnt_r <= 4'd9);
      default:   legal_s = 1'b0;
    endcase
  end

  // A new job is taken when idle, in the done cycle, or mid-job if restarts are enabled
  always_comb begin
    accept_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: accept_s = start;
      ST_KEYEXP, ST_INIT, ST_ROUND, ST_FINAL: accept_s = start && RESTART_ON_START;
      default: accept_s = 1'b0;
    endcase
  end

  // Shared S-box input: last key word when expanding, freshly derived w3 when reversing
  always_comb begin
    prev_w3_s = key_r[31:0] ^ key_r[63:32];
    if (state_r == ST_KEYEXP) begin
      sb_in_s  = key_r[31:0];
      rc_idx_s = rcnt_r;
    end else begin
      sb_in_s  = prev_w3_s;
      rc_idx_s = rcnt_r + 4'd1;
    end
  end

  assign rot_s     = {sb_in_s[23:0], sb_in_s[31:24]};
  assign rc_word_s = {rcon(rc_idx_s), 24'h000000};
  // Column 0 has the same form in both directions: w0 ^ SubWord(RotWord(.)) ^ rcon
  assign w0_s      = key_r[127:96] ^ sub_s ^ rc_word_s;

  assign next_key_s = {w0_s,
                       key_r[95:64] ^ w0_s,
                       key_r[63:32] ^ key_r[95:64] ^ w0_s,
                       key_r[31:0]  ^ key_r[63:32] ^ key_r[95:64] ^ w0_s};
  assign prev_key_s = {w0_s,
                       key_r[95:64] ^ key_r[127:96],
                       key_r[63:32] ^ key_r[95:64],
                       prev_w3_s};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_key_sbox
    aes_sbox u_sbox (.x(rot_s[8*g +: 8]), .y(sub_s[8*g +: 8]));
  end

  assign isr_s = inv_shift_rows(blk_r);
  for (g = 0; g < 16; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (.x(isr_s[8*g +: 8]), .y(isb_s[8*g +: 8]));
  end
  assign ark_s   = isb_s ^ prev_key_s;
  assign round_s = inv_mix_columns(ark_s);

  // Next-state and datapath update; a control fault overrides everything else
  always_comb begin
    state_n = state_r;
    rcnt_n  = rcnt_r;
    key_n   = key_r;
    blk_n   = blk_r;
    pt_n    = pt_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    fault_n = fault_r;
    if (!legal_s) begin
      fault_n = 1'b1;
      state_n = ST_IDLE;
      rcnt_n  = 4'd0;
      busy_n  = 1'b0;
    end else if (accept_s) begin
      key_n   = key;
      blk_n   = data;
      state_n = ST_KEYEXP;
      rcnt_n  = 4'd1;
      busy_n  = 1'b1;
    end else begin
      case (state_r)
        ST_KEYEXP: begin
          key_n = next_key_s;
          if (rcnt_r == RCNT_LAST) begin
            state_n = ST_INIT;
          end else begin
            rcnt_n = rcnt_r + 4'd1;
          end
        end
        ST_INIT: begin
          blk_n   = blk_r ^ key_r;
          state_n = ST_ROUND;
          rcnt_n  = 4'd9;
        end
        ST_ROUND: begin
          key_n = prev_key_s;
          blk_n = round_s;
          if (rcnt_r == 4'd1) begin
            state_n = ST_FINAL;
            rcnt_n  = 4'd0;
          end else begin
            rcnt_n = rcnt_r - 4'd1;
          end
        end
        ST_FINAL: begin
          key_n   = prev_key_s;
          blk_n   = ark_s;
          pt_n    = ark_s;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_DONE;
        end
        ST_DONE: state_n = ST_IDLE;
        ST_IDLE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Control, key, state and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      rcnt_r  <= 4'd0;
      key_r   <= 128'h0;
      blk_r   <= 128'h0;
      pt_r    <= 128'h0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_n;
      rcnt_r  <= rcnt_n;
      key_r   <= key_n;
      blk_r   <= blk_n;
      pt_r    <= pt_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      fault_r <= fault_n;
    end
  end

  assign plaintext      = pt_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign fault_detected = fault_r;

endmodule

// File: tb/tb_aes_128_inv.sv
// Directed bench for aes_128_inv: FIPS-197 vectors, latency, back-to-back,
// start-while-busy for both parameter values, async reset and fault flag.
module tb_aes_128_inv;
  import aes_pkg::*;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] K3 = 128'h0;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] P3 = 128'h0;

  logic         clock, reset, start;
  logic [127:0] key, data;
  logic [127:0] pt0, pt1;
  logic         busy0, busy1, done0, done1, fault0, fault1;

  int n_checks = 0;
  int n_fails  = 0;
  int lat, bcyc;
  int nd0, nd1, td0, td1;
  logic [127:0] cap0, cap1;

  aes_128_inv #(.RESTART_ON_START(1'b0)) dut0 (
    .clock(clock), .reset(reset), .start(start), .key(key), .data(data),
    .plaintext(pt0), .busy(busy0), .done(done0), .fault_detected(fault0));

  aes_128_inv #(.RESTART_ON_START(1'b1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .key(key), .data(data),
    .plaintext(pt1), .busy(busy1), .done(done1), .fault_detected(fault1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; start is sampled by the following posedge.
  task automatic do_start(input logic [127:0] k, input logic [127:0] d);
    key   = k;
    data  = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // t0 = edges already elapsed since the start edge; returns done latency and busy cycles seen.
  task automatic wait_done(input int t0, output int l, output int b);
    l = -1;
    b = 0;
    for (int i = t0; i < 60 && l < 0; i++) begin
      if (busy0) b++;
      if (done0) l = i;
      else @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    key   = 128'h0;
    data  = 128'h0;
    @(negedge clock);
    @(negedge clock);
    check_eq("rst_pt",    pt0, 128'h0);
    check_eq("rst_busy",  128'(busy0), 128'h0);
    check_eq("rst_done",  128'(done0), 128'h0);
    check_eq("rst_fault", 128'(fault0), 128'h0);
    reset = 1'b1;
    @(negedge clock);

    // Vector 1
    do_start(K1, C1);
    wait_done(0, lat, bcyc);
    check_eq("v1_latency", 128'(lat), 128'd21);
    check_eq("v1_pt", pt0, P1);
    check_eq("v1_pt_r1", pt1, P1);
    check_eq("v1_done_r1", 128'(done1), 128'h1);

    // Vector 2, issued in the done cycle of vector 1
    do_start(K2, C2);
    wait_done(0, lat, bcyc);
    check_eq("v2_latency", 128'(lat), 128'd21);
    check_eq("v2_busy_cycles", 128'(bcyc), 128'd21);
    check_eq("v2_pt", pt0, P2);

    // Vector 3 then back-to-back vector 1
    do_start(K3, C3);
    wait_done(0, lat, bcyc);
    check_eq("v3_latency", 128'(lat), 128'd21);
    check_eq("v3_pt", pt0, P3);
    do_start(K1, C1);
    check_eq("b2b_busy", 128'(busy0), 128'h1);
    for (int i = 0; i < 10; i++) @(negedge clock);
    check_eq("b2b_pt_held", pt0, P3);
    wait_done(10, lat, bcyc);
    check_eq("b2b_latency", 128'(lat), 128'd21);
    check_eq("b2b_pt", pt0, P1);

    // Start while busy: dut0 ignores it, dut1 restarts with vector 2
    @(negedge clock);
    @(negedge clock);
    do_start(K1, C1);
    for (int i = 1; i < 5; i++) @(negedge clock);
    do_start(K2, C2);
    nd0 = 0; nd1 = 0; td0 = -1; td1 = -1; cap0 = 128'h0; cap1 = 128'h0;
    for (int t = 5; t < 45; t++) begin
      if (done0) begin nd0++; td0 = t; cap0 = pt0; end
      if (done1) begin nd1++; td1 = t; cap1 = pt1; end
      @(negedge clock);
    end
    check_eq("ign_done_count", 128'(nd0), 128'd1);
    check_eq("ign_done_time", 128'(td0), 128'd21);
    check_eq("ign_pt", cap0, P1);
    check_eq("rst_on_done_count", 128'(nd1), 128'd1);
    check_eq("rst_on_done_time", 128'(td1), 128'd26);
    check_eq("rst_on_pt", cap1, P2);

    // Asynchronous reset in cycle 12 of a job
    do_start(K2, C2);
    for (int i = 1; i < 12; i++) @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("arst_pt",   pt0, 128'h0);
    check_eq("arst_busy", 128'(busy0), 128'h0);
    check_eq("arst_done", 128'(done0), 128'h0);
    @(negedge clock);
    reset = 1'b1;
    nd0 = 0;
    for (int i = 0; i < 30; i++) begin
      if (done0 || busy0) nd0++;
      @(negedge clock);
    end
    check_eq("arst_no_done", 128'(nd0), 128'h0);

    // Illegal FSM encoding on dut0
    do_start(K1, C1);
    @(negedge clock);
    @(negedge clock);
    force dut0.state_r = aes_state_e'(3'd7);
    @(negedge clock);
    release dut0.state_r;
    @(negedge clock);
    check_eq("fault_set",  128'(fault0), 128'h1);
    check_eq("fault_busy", 128'(busy0), 128'h0);
    nd0 = 0;
    for (int i = 0; i < 30; i++) begin
      if (done0) nd0++;
      @(negedge clock);
    end
    check_eq("fault_no_done", 128'(nd0), 128'h0);
    check_eq("fault_r1_clear", 128'(fault1), 128'h0);
    do_start(K2, C2);
    wait_done(0, lat, bcyc);
    check_eq("fault_job_pt", pt0, P2);
    check_eq("fault_sticky", 128'(fault0), 128'h1);
    reset = 1'b0;
    #1;
    check_eq("fault_cleared", 128'(fault0), 128'h0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
